pwm_dac_gen: RTL and testbench

PWM_DAC_GEN -- requirements
Module: pwm_dac_gen

---
 rtl/pwm_dac_gen.sv | 66 ++++++
 tb/tb_pwm_dac_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dac_gen.sv
// Dithered PWM DAC: a 256-cycle PWM period whose duty is bumped by one per period
// according to a 16-bit dither pattern, with the configuration shadowed per 16-period frame.
module pwm_dac_gen #(
  parameter int CCW = 24
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           en_i,
  input  logic [CCW-1:0] cfg_i,
  output logic           pwm_o,
  output logic           frame_o,
  output logic [CCW-1:0] cfg_o
);

  logic [7:0]  cnt;
  logic [3:0]  frm;
  logic [7:0]  duty_r;
  logic [15:0] pat_r;
  logic [8:0]  thresh;
  logic        frame_end;

  // Threshold spans 0..256 so both constant-low and constant-high are reachable.
  assign thresh    = {1'b0, duty_r} + {8'd0, pat_r[frm]};
  assign frame_end = (cnt == 8'hFF) && (frm == 4'hF);
  assign cfg_o     = {duty_r, pat_r};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
      frm <= '0;
    end else if (!en_i) begin
      cnt <= '0;
      frm <= '0;
    end else begin
      cnt <= cnt + 8'd1;
      if (cnt == 8'hFF) begin
        frm <= frm + 4'd1;
      end
    end
  end

  // While disabled the shadow tracks cfg_i, so re-enabling starts from the last value seen.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      duty_r <= '0;
      pat_r  <= '0;
    end else if (!en_i || frame_end) begin
      duty_r <= cfg_i[23:16];
      pat_r  <= cfg_i[15:0];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pwm_o   <= 1'b0;
      frame_o <= 1'b0;
    end else if (!en_i) begin
      pwm_o   <= 1'b0;
      frame_o <= 1'b0;
    end else begin
      pwm_o   <= ({1'b0, cnt} < thresh);
      frame_o <= frame_end;
    end
  end

endmodule

// File: tb/tb_pwm_dac_gen.sv
// Bench for pwm_dac_gen: a frame-position reference model checks every cycle,
// directed steps check per-period high counts, load timing, enable and reset behaviour.
module tb_pwm_dac_gen;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [23:0] cfg;
  logic        pwm;
  logic        frame;
  logic [23:0] cfg_rb;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: position within the frame (0..4095) plus the applied configuration.
  int          m_pos;
  logic [23:0] m_shadow;
  logic        m_pwm;
  logic        m_frame;

  int highs[16];
  int pulses;

  pwm_dac_gen #(.CCW(24)) dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .en_i    (en),
    .cfg_i   (cfg),
    .pwm_o   (pwm),
    .frame_o (frame),
    .cfg_o   (cfg_rb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos    = 0;
    m_shadow = '0;
    m_pwm    = 1'b0;
    m_frame  = 1'b0;
  endtask

  task automatic model_update();
    int thr;
    if (!rstn) begin
      model_reset();
    end else if (!en) begin
      m_pos    = 0;
      m_shadow = cfg;
      m_pwm    = 1'b0;
      m_frame  = 1'b0;
    end else begin
      thr     = int'(m_shadow[23:16]) + int'(m_shadow[m_pos / 256]);
      m_pwm   = (m_pos % 256) < thr;
      m_frame = (m_pos == 4095);
      if (m_pos == 4095) m_shadow = cfg;
      m_pos = (m_pos + 1) % 4096;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 16; i++) highs[i] = 0;
    pulses = 0;
  endtask

  function automatic int total_highs();
    int s = 0;
    for (int i = 0; i < 16; i++) s += highs[i];
    return s;
  endfunction

  task automatic apply_stimulus(input logic en_v, input logic [23:0] cfg_v);
    en  = en_v;
    cfg = cfg_v;
  endtask

  // One clock: update the model on the edge, compare just after it.
  task automatic step();
    int   pre_pos;
    logic pre_en;
    @(posedge clk);
    pre_pos = m_pos;
    pre_en  = en && rstn;
    model_update();
    #1;
    check_output("pwm_o", {31'd0, pwm}, {31'd0, m_pwm});
    check_output("frame_o", {31'd0, frame}, {31'd0, m_frame});
    check_output("cfg_o", {8'd0, cfg_rb}, {8'd0, m_shadow});
    if (pre_en) begin
      highs[pre_pos / 256] += int'(pwm);
      pulses += int'(frame);
    end
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame_window();
    clear_counts();
    run_steps(4096);
  endtask

  initial begin
    rstn = 1'b0;
    apply_stimulus(1'b0, 24'h000000);
    model_reset();
    #3;
    check_output("reset_pwm", {31'd0, pwm}, 32'd0);
    check_output("reset_frame", {31'd0, frame}, 32'd0);
    check_output("reset_cfg", {8'd0, cfg_rb}, 32'd0);
    run_steps(3);

    // First frame after reset runs on the zero configuration.
    #2;
    rstn = 1'b1;
    apply_stimulus(1'b1, 24'h800000);
    frame_window();
    check_output("first_frame_highs", total_highs(), 0);
    check_output("first_frame_pulses", pulses, 1);
    check_output("load_800000", {8'd0, cfg_rb}, 32'h800000);
    frame_window();
    check_output("half_duty_highs", total_highs(), 2048);
    check_output("half_duty_p0", highs[0], 128);
    check_output("half_duty_p15", highs[15], 128);
    check_output("half_duty_pulses", pulses, 1);

    apply_stimulus(1'b1, 24'hFFFFFF);
    frame_window();
    frame_window();
    check_output("full_high_highs", total_highs(), 4096);

    apply_stimulus(1'b1, 24'hFF0000);
    frame_window();
    frame_window();
    check_output("ff_duty_highs", total_highs(), 4080);
    check_output("ff_duty_p3", highs[3], 255);

    apply_stimulus(1'b1, 24'h000000);
    frame_window();
    frame_window();
    check_output("zero_highs", total_highs(), 0);

    apply_stimulus(1'b1, 24'h400080);
    frame_window();
    frame_window();
    check_output("dither_total", total_highs(), 1025);
    check_output("dither_p7", highs[7], 65);
    check_output("dither_p6", highs[6], 64);
    check_output("dither_p8", highs[8], 64);

    // Mid-frame configuration change only takes effect at the frame boundary.
    apply_stimulus(1'b1, 24'h200000);
    frame_window();
    run_steps(1000);
    apply_stimulus(1'b1, 24'hC00000);
    run_steps(3095);
    check_output("hold_cfg_before_end", {8'd0, cfg_rb}, 32'h200000);
    step();
    check_output("pulse_at_load", {31'd0, frame}, 32'd1);
    check_output("cfg_at_load", {8'd0, cfg_rb}, 32'hC00000);
    clear_counts();
    run_steps(256);
    check_output("period_after_load", highs[0], 192);

    // Disable while high, then re-enable with a new value held.
    run_steps(50);
    check_output("high_before_disable", {31'd0, pwm}, 32'd1);
    apply_stimulus(1'b0, 24'h100000);
    step();
    check_output("low_after_disable", {31'd0, pwm}, 32'd0);
    run_steps(4);
    apply_stimulus(1'b1, 24'h100000);
    clear_counts();
    step();
    check_output("reenable_no_pulse", {31'd0, frame}, 32'd0);
    check_output("reenable_first_high", {31'd0, pwm}, 32'd1);
    run_steps(255);
    check_output("reenable_period_highs", highs[0], 16);

    // Asynchronous reset between edges mid-frame.
    run_steps(10);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_output("async_rst_pwm", {31'd0, pwm}, 32'd0);
    check_output("async_rst_frame", {31'd0, frame}, 32'd0);
    check_output("async_rst_cfg", {8'd0, cfg_rb}, 32'd0);
    run_steps(3);
    #2;
    rstn = 1'b1;
    apply_stimulus(1'b1, 24'h800000);
    frame_window();
    check_output("post_rst_frame_highs", total_highs(), 0);
    check_output("post_rst_load", {8'd0, cfg_rb}, 32'h800000);

    // Randomized configuration and occasional enable drops against the model.
    for (int i = 0; i < 9000; i++) begin
      if (en && ($urandom_range(0, 599) == 0))
        apply_stimulus(1'b0, 24'($urandom));
      else if (!en && ($urandom_range(0, 3) == 0))
        apply_stimulus(1'b1, 24'($urandom));
      else
        apply_stimulus(en, 24'($urandom));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
